// File: rtl/mux_sel_ctrl_if.sv
// Signal bundle between the board-side controls and the mux input-conditioning stage.
// The master side drives buttons/switches; the slave side (mux_sel_ctrl) drives X0..X3, Y and load_ack.
interface mux_sel_ctrl_if #(
    parameter int W = 2
);
    logic         btn_next;
    logic         btn_prev;
    logic         btn_load;
    logic         sw_mode;
    logic [1:0]   sw_idx;
    logic [W-1:0] sw_data;
    logic [W-1:0] X0;
    logic [W-1:0] X1;
    logic [W-1:0] X2;
    logic [W-1:0] X3;
    logic [1:0]   Y;
    logic         load_ack;

    modport master (
        output btn_next, btn_prev, btn_load, sw_mode, sw_idx, sw_data,
        input  X0, X1, X2, X3, Y, load_ack
    );

    modport slave (
        input  btn_next, btn_prev, btn_load, sw_mode, sw_idx, sw_data,
        output X0, X1, X2, X3, Y, load_ack
    );
endinterface

// File: rtl/mux_sel_ctrl.sv
// Button synchronise/debounce, manual or auto-scan stepping of mux select Y,
// and the four switch-loaded data words X0..X3 feeding the 4-to-1 mux.
module mux_sel_ctrl #(
    parameter int W               = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_PERIOD     = 8
) (
    input  logic          clk,
    input  logic          rst,
    mux_sel_ctrl_if.slave bus
);
    localparam int NB      = 3;
    localparam int BI_NEXT = 0;
    localparam int BI_PREV = 1;
    localparam int BI_LOAD = 2;
    localparam int DW      = $clog2(DEBOUNCE_CYCLES);
    localparam int SCW     = $clog2(SCAN_PERIOD);
    localparam logic [DW-1:0]  DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_PERIOD - 1);

    logic [NB-1:0]  w_btn_raw;
    logic [NB-1:0]  w_press;
    logic           r_mode_s1;
    logic           r_mode_s2;
    logic [SCW-1:0] r_scan;
    logic [1:0]     r_y;
    logic           r_load_ack;
    logic [W-1:0]   r_x [4];

    assign w_btn_raw = {bus.btn_load, bus.btn_prev, bus.btn_next};

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_btn
            logic          r_sync1;
            logic          r_sync2;
            logic          r_stable;
            logic          r_stable_q;
            logic [DW-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1    <= 1'b0;
                    r_sync2    <= 1'b0;
                    r_stable   <= 1'b0;
                    r_stable_q <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_sync1    <= w_btn_raw[gi];
                    r_sync2    <= r_sync1;
                    r_stable_q <= r_stable;
                    // Any return to the accepted level restarts the qualification window.
                    if (r_sync2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_stable <= r_sync2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + DW'(1);
                    end
                end
            end

            assign w_press[gi] = r_stable & ~r_stable_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
        end else begin
            r_mode_s1 <= bus.sw_mode;
            r_mode_s2 <= r_mode_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y        <= 2'd0;
            r_scan     <= '0;
            r_load_ack <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_x[i] <= '0;
            end
        end else begin
            r_load_ack <= w_press[BI_LOAD];
            if (w_press[BI_LOAD]) begin
                r_x[bus.sw_idx] <= bus.sw_data;
            end
            // Holding the scan count at zero in manual mode makes every entry to auto
            // mode start a full period, and leaving it abandons any partial count.
            if (r_mode_s2) begin
                if (r_scan == SCAN_LAST) begin
                    r_scan <= '0;
                    r_y    <= r_y + 2'd1;
                end else begin
                    r_scan <= r_scan + SCW'(1);
                end
            end else begin
                r_scan <= '0;
                if (w_press[BI_NEXT] && !w_press[BI_PREV]) begin
                    r_y <= r_y + 2'd1;
                end else if (w_press[BI_PREV] && !w_press[BI_NEXT]) begin
                    r_y <= r_y - 2'd1;
                end
            end
        end
    end

    assign bus.X0       = r_x[0];
    assign bus.X1       = r_x[1];
    assign bus.X2       = r_x[2];
    assign bus.X3       = r_x[3];
    assign bus.Y        = r_y;
    assign bus.load_ack = r_load_ack;
endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Self-checking bench for mux_sel_ctrl: table of press/load vectors, directed
// latency/bounce/auto-scan/reset sequences, and a randomized run against a press-level model.
module tb_mux_sel_ctrl;
    localparam int W  = 2;
    localparam int DC = 4;
    localparam int SP = 8;
    localparam int N  = 400;

    typedef struct {
        bit nxt;
        bit prv;
        bit ld;
        int idx;
        int dat;
        int hold;
        int exp_y;
        int exp_x0;
        int exp_x1;
        int exp_x2;
        int exp_x3;
        int exp_acks;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_miss = 0;
    int   ack_cnt = 0;
    bit   raw [3][N];
    bit   act [3][N];
    int   ridx [N];
    int   rdat [N];

    mux_sel_ctrl_if #(.W(W)) bus ();

    mux_sel_ctrl #(.W(W), .DEBOUNCE_CYCLES(DC), .SCAN_PERIOD(SP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.load_ack === 1'b1) ack_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, actual, expected);
        end
    endtask

    task automatic chk_state(input string nm, input int y, input int x0, input int x1,
                             input int x2, input int x3);
        chk({nm, " Y"}, 32'(bus.Y), y);
        chk({nm, " X0"}, 32'(bus.X0), x0);
        chk({nm, " X1"}, 32'(bus.X1), x1);
        chk({nm, " X2"}, 32'(bus.X2), x2);
        chk({nm, " X3"}, 32'(bus.X3), x3);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_btns();
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        bus.btn_load = 1'b0;
    endtask

    // Asserts rst between edges and checks the outputs clear before any clock edge.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        chk_state("async reset", 0, 0, 0, 0, 0);
        chk("async reset load_ack", 32'(bus.load_ack), 0);
        @(posedge clk);
        #4 rst = 1'b0;
        tick(1);
    endtask

    task automatic press(input bit nx, input bit pv, input bit ld, input int idx,
                         input int dat, input int hold);
        bus.btn_next = nx;
        bus.btn_prev = pv;
        bus.btn_load = ld;
        bus.sw_idx   = idx[1:0];
        bus.sw_data  = dat[W-1:0];
        tick(hold);
        release_btns();
        tick(DC + 6);
    endtask

    initial begin
        vec_t tbl [10];
        bit   bseq [5];
        int   a0;
        int   y;
        int   xm [4];
        int   c;
        int   len;

        release_btns();
        bus.sw_mode = 1'b0;
        bus.sw_idx  = 2'd0;
        bus.sw_data = '0;

        tbl[0] = '{1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 0, 0, 0, 5, 2, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 0, 0, 0, 0, 5, 3, 0, 0, 0, 0, 0};
        tbl[4] = '{1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{0, 1, 0, 0, 0, 5, 3, 0, 0, 0, 0, 0};
        tbl[6] = '{0, 0, 1, 2, 2, 5, 3, 0, 0, 2, 0, 1};
        tbl[7] = '{0, 0, 1, 0, 3, 4, 3, 3, 0, 2, 0, 1};
        tbl[8] = '{0, 0, 1, 1, 1, 3, 3, 3, 0, 2, 0, 0};
        tbl[9] = '{0, 1, 1, 3, 1, 8, 2, 3, 0, 2, 1, 1};
        bseq   = '{1, 0, 1, 1, 0};

        // Reset state and idle after release
        tick(3);
        chk_state("reset held", 0, 0, 0, 0, 0);
        chk("reset held load_ack", 32'(bus.load_ack), 0);
        @(posedge clk);
        #4 rst = 1'b0;
        tick(12);
        chk("idle after reset Y", 32'(bus.Y), 0);

        // Exact press latency: action on the 7th edge counting the first sampling edge
        bus.btn_next = 1'b1;
        tick(6);
        chk("latency edge6 Y", 32'(bus.Y), 0);
        tick(1);
        chk("latency edge7 Y", 32'(bus.Y), 1);
        tick(3);
        chk("held no repeat Y", 32'(bus.Y), 1);
        release_btns();
        tick(DC + 6);
        $display("latency: next held 10 cycles -> Y=%0d", bus.Y);

        for (int i = 0; i < 10; i++) begin
            a0 = ack_cnt;
            press(tbl[i].nxt, tbl[i].prv, tbl[i].ld, tbl[i].idx, tbl[i].dat, tbl[i].hold);
            chk_state($sformatf("tbl[%0d]", i), tbl[i].exp_y, tbl[i].exp_x0, tbl[i].exp_x1,
                      tbl[i].exp_x2, tbl[i].exp_x3);
            chk($sformatf("tbl[%0d] ack cycles", i), 32'(ack_cnt - a0), 32'(tbl[i].exp_acks));
            $display("tbl[%0d] next=%0d prev=%0d load=%0d hold=%0d -> Y=%0d acks=%0d", i,
                     tbl[i].nxt, tbl[i].prv, tbl[i].ld, tbl[i].hold, bus.Y, ack_cnt - a0);
        end

        // Bouncing press gives exactly one step (Y 2 -> 3)
        for (int i = 0; i < 5; i++) begin
            bus.btn_next = bseq[i];
            tick(1);
        end
        bus.btn_next = 1'b1;
        tick(8);
        release_btns();
        tick(DC + 6);
        chk("bounce Y", 32'(bus.Y), 3);
        $display("bounce: 1,0,1,1,0 then steady -> Y=%0d", bus.Y);

        press(0, 1, 0, 0, 0, 5);
        chk("pre-auto Y", 32'(bus.Y), 2);

        // Auto-scan: mode synced after edge 2, steps at edges 10, 18, 26
        bus.sw_mode = 1'b1;
        tick(9);
        chk("auto edge9 Y", 32'(bus.Y), 2);
        tick(1);
        chk("auto edge10 Y", 32'(bus.Y), 3);
        bus.btn_next = 1'b1;
        tick(5);
        release_btns();
        tick(2);
        chk("auto next ignored Y", 32'(bus.Y), 3);
        tick(1);
        chk("auto edge18 Y", 32'(bus.Y), 0);
        tick(8);
        chk("auto edge26 Y", 32'(bus.Y), 1);
        tick(3);
        bus.sw_mode = 1'b0;
        tick(11);
        chk("manual freeze Y", 32'(bus.Y), 1);
        $display("auto-scan: Y 2->3->0->1 then frozen at %0d", bus.Y);

        // Reset mid-run with X2=3, Y=2
        press(0, 0, 1, 2, 3, 5);
        press(1, 0, 0, 0, 0, 5);
        chk_state("pre-reset", 2, 3, 0, 3, 1);
        pulse_reset();
        tick(12);
        chk_state("post-reset idle", 0, 0, 0, 0, 0);
        $display("mid-run reset: outputs cleared, Y=%0d", bus.Y);

        // Reset while a load press is two counts into its debounce
        bus.sw_idx   = 2'd1;
        bus.sw_data  = 2'd2;
        bus.btn_load = 1'b1;
        tick(4);
        a0 = ack_cnt;
        pulse_reset();
        tick(5);
        chk("reset-press early acks", 32'(ack_cnt - a0), 0);
        chk("reset-press early X1", 32'(bus.X1), 0);
        tick(15);
        release_btns();
        tick(DC + 6);
        chk("reset-press total acks", 32'(ack_cnt - a0), 1);
        chk_state("reset-press", 0, 0, 2, 0, 0);
        $display("reset mid-press: acks=%0d X1=%0d", ack_cnt - a0, bus.X1);

        // Randomized clean presses against a press-level model
        pulse_reset();
        tick(10);
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < N; k++) begin
                raw[b][k] = 1'b0;
                act[b][k] = 1'b0;
            end
            c = 8 + b;
            while (1) begin
                len = int'($urandom_range(1, 2 * DC + 2));
                if (c + len >= N - 20) break;
                for (int k = 0; k < len; k++) raw[b][c + k] = 1'b1;
                if (len >= DC) act[b][c + DC + 2] = 1'b1;
                c += len + int'($urandom_range(DC, DC + 6));
            end
        end
        for (int k = 0; k < N; k++) begin
            ridx[k] = int'($urandom_range(0, 3));
            rdat[k] = int'($urandom_range(0, 3));
        end
        y  = 0;
        xm = '{0, 0, 0, 0};
        for (int k = 0; k < N; k++) begin
            bus.btn_next = raw[0][k];
            bus.btn_prev = raw[1][k];
            bus.btn_load = raw[2][k];
            bus.sw_idx   = ridx[k][1:0];
            bus.sw_data  = rdat[k][W-1:0];
            tick(1);
            if (act[0][k] && !act[1][k]) y = (y + 1) % 4;
            else if (act[1][k] && !act[0][k]) y = (y + 3) % 4;
            if (act[2][k]) xm[ridx[k]] = rdat[k];
            chk_state($sformatf("rnd[%0d]", k), y, xm[0], xm[1], xm[2], xm[3]);
            chk($sformatf("rnd[%0d] load_ack", k), 32'(bus.load_ack), 32'(act[2][k]));
            if (act[0][k] || act[1][k] || act[2][k])
                $display("rnd[%0d] next=%0d prev=%0d load=%0d idx=%0d data=%0d -> Y=%0d",
                         k, act[0][k], act[1][k], act[2][k], ridx[k], rdat[k], bus.Y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        n_vec++;
        n_miss++;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
